// File: rtl/instruction_pkg.sv
// Shared definitions for the instruction memory write (loader) and fetch paths.
// Both ends use the same word size and byte-lane order.
package instruction_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned INST_W         = 32;

    // MSB lane leaves first, so the fetch side rebuilds [31:24],[23:16],[15:8],[7:0].
    localparam int unsigned FIRST_LANE = BYTES_PER_WORD - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } loader_state_t;

    function automatic logic [7:0] lane_byte(input logic [INST_W-1:0] word, input int unsigned lane);
        lane_byte = word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/instruction_write_pointer.sv
// Loadable, saturating byte-address counter with word-aligned parallel load and full detect.
// Write-side mirror of the fetch program counter.
module instruction_write_pointer #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              full_o
);

    localparam logic [ADDR_W-1:0] PTR_MAX    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FULL_LIMIT = PTR_MAX - ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer: aligned load wins, otherwise increment until the top byte and hold there.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_addr_i & ALIGN_MASK;
        end else if (inc_i && (ptr_q != PTR_MAX)) begin
            ptr_d = ptr_q + PTR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign full_o = (ptr_q > FULL_LIMIT);

endmodule

// File: rtl/instruction_memory_loader.sv
// Accepts 32-bit words over valid/ready and writes them MSB first as four
// consecutive bytes into the byte-wide instruction memory.
module instruction_memory_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadAddrFlag,
    input  logic [ADDR_W-1:0] loadAddress,
    input  logic              inValid,
    input  logic [INST_W-1:0] inInstruction,
    output logic              inReady,
    output logic              memWren,
    output logic [ADDR_W-1:0] memAddress,
    output logic [7:0]        memData,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W-3:0] wordCount
);

    import instruction_pkg::*;

    localparam logic [ADDR_W-3:0] CNT_MAX = {(ADDR_W-2){1'b1}};
    localparam logic [ADDR_W-3:0] CNT_ONE = (ADDR_W-2)'(1);

    loader_state_t     state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [INST_W-1:0] shift_q, shift_d;
    logic [ADDR_W-3:0] cnt_q, cnt_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              load_s;
    logic              full_s;
    logic [ADDR_W-1:0] ptr_s;

    // A word may enter when idle or on the last byte of the current one; an address load blocks it.
    assign in_ready_s = rst && !full_s && !loadAddrFlag &&
                        ((state_q == IDLE) || (idx_q == 2'd3));
    assign accept_s   = inValid && in_ready_s;
    assign load_s     = loadAddrFlag && (state_q == IDLE);

    instruction_write_pointer #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk         (clk),
        .rst_n       (rst),
        .load_i      (load_s),
        .load_addr_i (loadAddress),
        .inc_i       (state_q == SEND),
        .ptr_o       (ptr_s),
        .full_o      (full_s)
    );

    // Next-state: serialize one byte per SEND cycle, chain the next word on the index-3 edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    cnt_d = '0;
                end else if (accept_s) begin
                    shift_d = inInstruction;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                shift_d = shift_q << 4'd8;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (accept_s) begin
                        shift_d = inInstruction;
                        idx_d   = 2'd0;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State, byte index, shift register and word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign inReady    = in_ready_s;
    assign memWren    = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign memAddress = ptr_s;
    assign memData    = lane_byte(shift_q, FIRST_LANE);
    assign full       = full_s;
    assign wordCount  = cnt_q;

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Write-side counterpart of the byte-serial instruction fetch path.
- Accepts 32-bit instruction words over a valid/ready handshake and writes each one into the 8-bit-wide instruction memory as 4 consecutive bytes, MSB first.
- Uses ascending addresses, so the fetch side reassembles bytes [31:24],[23:16],[15:8],[7:0] in order.
- Used at boot, or by a host link, to load the decryption program before the fetch unit runs.

Parameters:
- ADDR_W, 8, byte address width of the instruction memory. Memory depth is 2**ADDR_W bytes.
- INST_W, 32, instruction width. Fixed at 4 bytes; any other value is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- loadAddrFlag  input  1  load a new start address from loadAddress.
- loadAddress  input  ADDR_W  start byte address. Bits [1:0] are forced to 0 (word aligned).
- inValid  input  1  inInstruction is valid.
- inInstruction  input  32  instruction word to store.
- inReady  output  1  loader accepts a word this cycle.
- memWren  output  1  byte write enable to the instruction memory.
- memAddress  output  ADDR_W  byte write address.
- memData  output  8  byte write data.
- busy  output  1  a word is being serialized.
- full  output  1  fewer than 4 bytes remain above the write pointer.
- wordCount  output  ADDR_W-2  complete words written since reset or since the last address load.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, pointer=0, byte index=0, shift register=0, wordCount=0.
- memWren=0, memAddress=0, memData=0, inReady=0, busy=0, full=0.
- Reset mid-word abandons the partial word. Bytes already written stay in memory.

States:
- IDLE: no write in progress.
- SEND: 4 byte cycles, index 0..3.

Handshake:
- A word is accepted on a rising edge where inValid=1 and inReady=1.
- inReady = !full && !loadAddrFlag && (state==IDLE || (state==SEND && index==3)).
- inInstruction must be held stable while inValid=1 and inReady=0.

Serialization:
- On accept, the word is latched into the shift register, index=0, state=SEND.
- In each SEND cycle:
  - memWren=1, memAddress=pointer, memData=shift[31:24].
  - At the next edge: pointer+1, shift<<8, index+1.
- Latency: first byte write is presented the cycle after the accept edge. Four write cycles per word.
- At index==3:
  - wordCount increments at the edge.
  - If a new word is accepted on that same edge, state stays SEND with index=0. This gives sustained throughput of 1 word per 4 cycles with no gap.
  - Otherwise state goes to IDLE.
- busy=1 exactly while state==SEND.
- Outputs are driven from registered state only; there is no combinational path from inValid or inInstruction to mem*.

Address load:
- loadAddrFlag is honoured only in IDLE: pointer={loadAddress[ADDR_W-1:2],2'b00}, wordCount=0.
- In SEND the flag is ignored. The caller holds it until busy=0.
- loadAddrFlag has priority over acceptance in the same cycle (inReady=0).

Full / boundary:
- full = (pointer > 2**ADDR_W-4), evaluated from the registered pointer.
- The pointer never wraps. When full, inReady=0 and no words are accepted until an address load or reset.
- A word starting at 2**ADDR_W-4 is accepted. After its last byte the pointer saturates at 2**ADDR_W-1 and full=1.
- wordCount saturates at its maximum and does not wrap.

Decomposition:
- Shared package instruction_pkg:
  - BYTES_PER_WORD=4, INST_W=32.
  - Enum loader_state_t {IDLE, SEND}.
  - Byte-lane order constant (MSB first), shared with the fetch side so both ends agree.
- One natural sub-module: instruction_write_pointer.
  - Loadable, saturating byte-address counter with aligned parallel load and full detect.
  - Write-side mirror of the fetch program counter.
- Handshake and shift register stay in the top module.

Test Plan:
- Reset then load 0x00, send 0xDEADBEEF → writes DE@0x00, AD@0x01, BE@0x02, EF@0x03 on cycles 1–4 after accept; wordCount=1; busy falls after byte 4.
- inValid held high with words 0x11223344 and 0x55667788 → second accepted on the index-3 edge; 8 consecutive memWren cycles at 0x00–0x07, no gap.
- loadAddrFlag=1, loadAddress=0x13 together with inValid → pointer=0x10; inReady=0 that cycle; word written at 0x10–0x13 after a later accept.
- Load 0xFC, send one word → bytes at 0xFC–0xFF, full=1; a further inValid sees inReady=0 and memWren stays 0.
- Drive rst low during byte index 2 of 0xCAFEF00D → memWren=0 immediately (asynchronous); after release pointer=0 and wordCount=0; next word writes from 0x00.
- Load 0x20 during SEND → ignored (pointer continues). Load after busy=0 → takes effect; wordCount=0.
